// File: rtl/conv_addr_gen.sv
// Address generator for z[i] = sum_j x[j]*y[i-j]: walks every i and only the valid j window,
// emitting one (j, i-j, i) tuple per ready/valid transfer with accumulator first/last flags.
`timescale 1ns/1ps

module conv_addr_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int ZADDR_WIDTH = DATA_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [DATA_WIDTH-1:0]  sizeX_i,
  input  logic [DATA_WIDTH-1:0]  sizeY_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  memX_addr_o,
  output logic [DATA_WIDTH-1:0]  memY_addr_o,
  output logic [ZADDR_WIDTH-1:0] memZ_addr_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [ZADDR_WIDTH-1:0] i_reg, j_reg;
  logic [ZADDR_WIDTH-1:0] xm1_reg, ym1_reg, end_reg;
  logic [DATA_WIDTH-1:0]  y_reg;
  logic                   valid_reg, first_reg, last_reg, busy_reg, done_reg;

  logic [ZADDR_WIDTH-1:0] i_next, j_next;
  logic [DATA_WIDTH-1:0]  y_next;
  logic                   first_next, last_next, job_end;

  // Compare before subtracting so the lower bound never goes negative.
  function automatic logic [ZADDR_WIDTH-1:0] jmin_f(input logic [ZADDR_WIDTH-1:0] i,
                                                    input logic [ZADDR_WIDTH-1:0] ym1);
    return (i > ym1) ? (i - ym1) : '0;
  endfunction

  function automatic logic [ZADDR_WIDTH-1:0] jmax_f(input logic [ZADDR_WIDTH-1:0] i,
                                                    input logic [ZADDR_WIDTH-1:0] xm1);
    return (i < xm1) ? i : xm1;
  endfunction

  always_comb begin
    i_next  = i_reg;
    j_next  = j_reg;
    job_end = 1'b0;
    if (!last_reg) begin
      j_next = j_reg + ZADDR_WIDTH'(1);
    end else if (i_reg < end_reg) begin
      i_next = i_reg + ZADDR_WIDTH'(1);
      j_next = jmin_f(i_reg + ZADDR_WIDTH'(1), ym1_reg);
    end else begin
      job_end = 1'b1;
    end
    first_next = (j_next == jmin_f(i_next, ym1_reg));
    last_next  = (j_next == jmax_f(i_next, xm1_reg));
    // i-j < sizeY, so the low bits of the difference carry the whole result.
    y_next     = i_next[DATA_WIDTH-1:0] - j_next[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      y_reg     <= '0;
      xm1_reg   <= '0;
      ym1_reg   <= '0;
      end_reg   <= '0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            xm1_reg  <= ZADDR_WIDTH'(sizeX_i) - ZADDR_WIDTH'(1);
            ym1_reg  <= ZADDR_WIDTH'(sizeY_i) - ZADDR_WIDTH'(1);
            end_reg  <= ZADDR_WIDTH'(sizeX_i) + ZADDR_WIDTH'(sizeY_i) - ZADDR_WIDTH'(2);
            i_reg    <= '0;
            j_reg    <= '0;
            y_reg    <= '0;
            busy_reg <= 1'b1;
            if (sizeX_i != '0 && sizeY_i != '0) begin
              // z[0] always has exactly one term, so the first tuple is both first and last.
              state_reg <= RUN;
              valid_reg <= 1'b1;
              first_reg <= 1'b1;
              last_reg  <= 1'b1;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        RUN: begin
          if (valid_reg && ready_i) begin
            if (job_end) begin
              state_reg <= DONE;
              valid_reg <= 1'b0;
              first_reg <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              i_reg     <= i_next;
              j_reg     <= j_next;
              y_reg     <= y_next;
              first_reg <= first_next;
              last_reg  <= last_next;
            end
          end
        end
        DONE: begin
          // Entered with done already raised after a run, or still low after an empty job.
          if (done_reg) begin
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign valid_o     = valid_reg;
  assign memX_addr_o = j_reg[DATA_WIDTH-1:0];
  assign memY_addr_o = y_reg;
  assign memZ_addr_o = i_reg;
  assign first_o     = first_reg;
  assign last_o      = last_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: expected tuple streams come from a direct nested-loop walk of the
// convolution index space; random backpressure and input disturbance are applied around it.
`timescale 1ns/1ps

module tb_conv_addr_gen;

  localparam int DW = 8;
  localparam int ZW = DW + 1;

  typedef logic [2*DW+ZW+1:0] tup_t;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [DW-1:0] sizeX_i;
  logic [DW-1:0] sizeY_i;
  logic          ready_i;
  logic          valid_o;
  logic [DW-1:0] memX_addr_o;
  logic [DW-1:0] memY_addr_o;
  logic [ZW-1:0] memZ_addr_o;
  logic          first_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  int n_vec = 0;
  int n_err = 0;

  conv_addr_gen #(.DATA_WIDTH(DW), .ZADDR_WIDTH(ZW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sizeX_i(sizeX_i), .sizeY_i(sizeY_i),
    .ready_i(ready_i), .valid_o(valid_o), .memX_addr_o(memX_addr_o),
    .memY_addr_o(memY_addr_o), .memZ_addr_o(memZ_addr_o), .first_o(first_o),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low on the 2nd and 3rd valid cycles.
  // disturb: scramble sizes every cycle and pulse start_i while the job is running.
  task automatic run_job(input int sx, input int sy, input int rmode, input bit disturb,
                         output int n_valid, output int done_cyc);
    tup_t exp_q[$];
    tup_t got;
    int   last_xfer;
    int   exp_done;
    int   c;
    bit   fin;
    exp_q.delete();
    for (int i = 0; i <= sx + sy - 2; i++) begin
      int lo, hi;
      lo = (i - (sy - 1) > 0) ? i - (sy - 1) : 0;
      hi = (i < sx - 1) ? i : sx - 1;
      for (int j = lo; j <= hi; j++)
        exp_q.push_back({DW'(j), DW'(i - j), ZW'(i), (j == lo), (j == hi)});
    end
    n_valid   = 0;
    done_cyc  = -1;
    last_xfer = 0;
    start_i   = 1'b1;
    sizeX_i   = DW'(sx);
    sizeY_i   = DW'(sy);
    ready_i   = 1'b0;
    tick();
    start_i = 1'b0;
    fin     = 1'b0;
    for (c = 1; c <= 70000 && !fin; c++) begin
      if (disturb) begin
        sizeX_i = DW'($urandom);
        sizeY_i = DW'($urandom);
        start_i = (c == 2);
      end
      if (done_o) begin
        exp_done = (sx * sy == 0) ? 2 : last_xfer + 1;
        n_vec++;
        if (exp_q.size() != 0 || c != exp_done || valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL done_timing sx=%0d sy=%0d got cycle=%0d left=%0d want cycle=%0d left=0",
                   sx, sy, c, exp_q.size(), exp_done);
        end
        done_cyc = c;
        fin      = 1'b1;
      end else if (valid_o) begin
        n_valid++;
        got = {memX_addr_o, memY_addr_o, memZ_addr_o, first_o, last_o};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_tuple sx=%0d sy=%0d cycle=%0d got=%h want=none", sx, sy, c, got);
        end else if (got !== exp_q[0] || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL tuple sx=%0d sy=%0d cycle=%0d got x=%0d y=%0d z=%0d f=%b l=%b busy=%b want %h busy=1",
                   sx, sy, c, memX_addr_o, memY_addr_o, memZ_addr_o, first_o, last_o, busy_o, exp_q[0]);
        end
        case (rmode)
          1:       ready_i = ($urandom_range(0, 2) != 0);
          2:       ready_i = !(n_valid == 2 || n_valid == 3);
          default: ready_i = 1'b1;
        endcase
        if (ready_i && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          last_xfer = c;
        end
      end else begin
        n_vec++;
        if (exp_q.size() != 0 || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL idle_gap sx=%0d sy=%0d cycle=%0d got busy=%b left=%0d want busy=1 left=0",
                   sx, sy, c, busy_o, exp_q.size());
        end
      end
      if (!fin) tick();
    end
    if (!fin) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout sx=%0d sy=%0d got no done_o want done_o", sx, sy);
    end
    start_i = 1'b0;
    ready_i = 1'b0;
    tick();
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_done sx=%0d sy=%0d got done=%b busy=%b valid=%b want 0 0 0",
               sx, sy, done_o, busy_o, valid_o);
    end
    $display("job sx=%0d sy=%0d rmode=%0d disturb=%0d valid_cycles=%0d done_cycle=%0d",
             sx, sy, rmode, disturb, n_valid, done_cyc);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_i = 1'b1;
    sizeX_i = 8'd5;
    sizeY_i = 8'd4;
    ready_i = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({valid_o, busy_o, done_o, first_o, last_o, memX_addr_o, memY_addr_o, memZ_addr_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b f=%b l=%b x=%0d y=%0d z=%0d want all 0",
               valid_o, busy_o, done_o, first_o, last_o, memX_addr_o, memY_addr_o, memZ_addr_o);
    end
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    n_vec++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_basic();
    int nv, dc;
    run_job(3, 2, 0, 1'b0, nv, dc);
    n_vec++;
    if (nv != 6 || dc != 7) begin
      n_err++;
      $display("FAIL basic_count got valid=%0d done=%0d want valid=6 done=7", nv, dc);
    end
  endtask

  task automatic test_backpressure();
    int nv, dc;
    run_job(3, 2, 2, 1'b0, nv, dc);
    n_vec++;
    if (nv != 8 || dc != 9) begin
      n_err++;
      $display("FAIL backpressure_count got valid=%0d done=%0d want valid=8 done=9", nv, dc);
    end
    for (int k = 0; k < 4; k++) run_job(1 + $urandom_range(0, 9), 1 + $urandom_range(0, 9), 1, 1'b0, nv, dc);
  endtask

  task automatic test_degenerate();
    int nv, dc;
    int szx[4] = '{0, 7, 0, 1};
    int szy[4] = '{5, 0, 0, 1};
    int env[4] = '{0, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      run_job(szx[k], szy[k], 0, 1'b0, nv, dc);
      n_vec++;
      if (nv != env[k] || dc != 2) begin
        n_err++;
        $display("FAIL degenerate sx=%0d sy=%0d got valid=%0d done=%0d want valid=%0d done=2",
                 szx[k], szy[k], nv, dc, env[k]);
      end
    end
  endtask

  task automatic test_asym_max();
    int nv, dc;
    run_job(1, 255, 0, 1'b0, nv, dc);
    n_vec++;
    if (nv != 255 || dc != 256) begin
      n_err++;
      $display("FAIL asym_1x255 got valid=%0d done=%0d want valid=255 done=256", nv, dc);
    end
    run_job(255, 1, 1, 1'b0, nv, dc);
    run_job(255, 255, 0, 1'b0, nv, dc);
    n_vec++;
    if (nv != 65025 || dc != 65026) begin
      n_err++;
      $display("FAIL max_255x255 got valid=%0d done=%0d want valid=65025 done=65026", nv, dc);
    end
  endtask

  task automatic test_reset_mid_job();
    int nv, dc;
    bit saw_done;
    start_i = 1'b1;
    sizeX_i = 8'd3;
    sizeY_i = 8'd2;
    ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    n_vec++;
    if (valid_o !== 1'b1 || memX_addr_o !== 8'd1 || memZ_addr_o !== 9'd1) begin
      n_err++;
      $display("FAIL mid_tuple3 got v=%b x=%0d z=%0d want v=1 x=1 z=1", valid_o, memX_addr_o, memZ_addr_o);
    end
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    ready_i  = 1'b0;
    saw_done = 1'b0;
    n_vec++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b b=%b d=%b want 0 0 0", valid_o, busy_o, done_o);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL mid_after got activity after abort want done=0 busy=0");
    end
    run_job(3, 2, 0, 1'b0, nv, dc);
    n_vec++;
    if (nv != 6 || dc != 7) begin
      n_err++;
      $display("FAIL mid_restart got valid=%0d done=%0d want valid=6 done=7", nv, dc);
    end
  endtask

  task automatic test_start_while_busy();
    int nv, dc;
    run_job(4, 3, 1, 1'b1, nv, dc);
    run_job(2, 5, 0, 1'b1, nv, dc);
    n_vec++;
    if (nv != 10 || dc != 11) begin
      n_err++;
      $display("FAIL busy_start got valid=%0d done=%0d want valid=10 done=11", nv, dc);
    end
  endtask

  task automatic test_random();
    int nv, dc;
    for (int k = 0; k < 20; k++)
      run_job($urandom_range(0, 12), $urandom_range(0, 12), 1, k[0], nv, dc);
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    sizeX_i = '0;
    sizeY_i = '0;
    ready_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate();
    test_asym_max();
    test_reset_mid_job();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
